// File: rtl/rvlab_tlul_host_mux.sv
// rvlab_tlul_host_mux: N-host to 1-device TL-UL mux, round-robin with grant lock.
// Optional: define RVLAB_TLUL_HOST_MUX_ERR_EN to consume and flag spurious responses.
package rvlab_tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module rvlab_tlul_host_mux
  import rvlab_tlul_pkg::*;
#(
  parameter int unsigned NumHosts       = 4,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned HostIdxW      = $clog2(NumHosts),
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  tl_h2d_t         tl_h_i [NumHosts],
  output tl_d2h_t         tl_h_o [NumHosts],
  output tl_h2d_t         tl_d_o,
  input  tl_d2h_t         tl_d_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            err_o
);

  localparam int unsigned PtrW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  typedef logic [HostIdxW-1:0] idx_t;
  typedef logic [PtrW-1:0]     ptr_t;

  function automatic idx_t wrap_add(input idx_t v, input idx_t k);
    logic [HostIdxW:0] s;
    s = {1'b0, v} + {1'b0, k};
    if (s >= (HostIdxW + 1)'(NumHosts)) begin
      s = s - (HostIdxW + 1)'(NumHosts);
    end
    return s[HostIdxW-1:0];
  endfunction

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p == PtrW'(MaxOutstanding - 1)) r = '0;
    else                                r = p + PtrW'(1);
    return r;
  endfunction

  state_e          state_q, state_d;
  idx_t            lock_idx_q, lock_idx_d;
  idx_t            rr_q, rr_d;
  idx_t            fifo_q [MaxOutstanding];
  ptr_t            wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  idx_t cand_idx, gnt_idx, head_idx;
  logic cand_vld, gnt_vld;
  logic full, nonempty;
  logic dev_a_valid, dev_d_ready;
  logic host_a_ready;
  logic push, pop;

  // First requesting host at or after rr_q; scanning backwards lets the
  // nearest one win without an early exit.
  always_comb begin
    cand_idx = rr_q;
    cand_vld = 1'b0;
    for (int unsigned k = 0; k < NumHosts; k++) begin
      if (tl_h_i[wrap_add(rr_q, idx_t'(NumHosts - 1 - k))].a_valid) begin
        cand_vld = 1'b1;
        cand_idx = wrap_add(rr_q, idx_t'(NumHosts - 1 - k));
      end
    end
  end

  assign gnt_idx  = (state_q == LOCKED) ? lock_idx_q : cand_idx;
  assign gnt_vld  = (state_q == LOCKED) ? tl_h_i[lock_idx_q].a_valid
                                        : cand_vld;
  assign full     = (cnt_q == CntW'(MaxOutstanding));
  assign nonempty = (cnt_q != '0);
  assign head_idx = fifo_q[rd_ptr_q];

  assign dev_a_valid  = gnt_vld && !full && !rst_i;
  assign host_a_ready = dev_a_valid && tl_d_i.a_ready;
  assign push         = host_a_ready;

`ifdef RVLAB_TLUL_HOST_MUX_ERR_EN
  assign dev_d_ready = !rst_i &&
    (nonempty ? tl_h_i[head_idx].d_ready : tl_d_i.d_valid);
`else
  assign dev_d_ready = !rst_i && nonempty && tl_h_i[head_idx].d_ready;
`endif

  assign pop = nonempty && tl_d_i.d_valid && dev_d_ready;

  always_comb begin
    tl_d_o         = tl_h_i[gnt_idx];
    tl_d_o.a_valid = dev_a_valid;
    tl_d_o.d_ready = dev_d_ready;
  end

  always_comb begin
    for (int unsigned i = 0; i < NumHosts; i++) begin
      tl_h_o[i] = '0;
      if (nonempty && head_idx == idx_t'(i)) begin
        tl_h_o[i] = tl_d_i;
      end
      tl_h_o[i].a_ready = host_a_ready && (gnt_idx == idx_t'(i));
    end
  end

  // Lock whenever a request is offered but not taken, so its fields hold.
  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      IDLE: begin
        if (dev_a_valid && !tl_d_i.a_ready) begin
          state_d    = LOCKED;
          lock_idx_d = gnt_idx;
        end
      end
      LOCKED: begin
        if (push) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rr_d = push ? wrap_add(gnt_idx, idx_t'(1)) : rr_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= gnt_idx;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      cnt_q <= cnt_d;
    end
  end

  assign outstanding_o = cnt_q;

`ifdef RVLAB_TLUL_HOST_MUX_ERR_EN
  logic err_q, err_d;

  assign err_d = err_q || (!nonempty && tl_d_i.d_valid);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err_o = err_q;

  a_no_push_full: assert property (
    @(posedge clk_i) disable iff (rst_i) push |-> !full
  );
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_rvlab_tlul_host_mux.sv
// tb_rvlab_tlul_host_mux: directed tests plus a cycle-level queue model
// of the host mux (arbitration, lock, response routing, occupancy).
module tb_rvlab_tlul_host_mux;
  import rvlab_tlul_pkg::*;

  localparam int N    = 4;
  localparam int MAXO = 4;
`ifdef RVLAB_TLUL_HOST_MUX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  tl_h2d_t     h     [N];
  tl_d2h_t     h_o   [N];
  tl_d2h_t     h2_o  [N];
  tl_h2d_t     d_o, d2_o;
  tl_d2h_t     d_i;
  logic [2:0]  outst;
  logic [1:0]  outst2;
  logic        err, err2;

  logic        dev_ardy;
  logic        auto_rsp;
  logic        man_dv;
  logic [31:0] man_data;
  logic        auto_dv;
  logic [31:0] auto_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rvlab_tlul_host_mux #(.NumHosts(N), .MaxOutstanding(MAXO)) u_dut (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h), .tl_h_o(h_o),
    .tl_d_o(d_o), .tl_d_i(d_i), .outstanding_o(outst), .err_o(err)
  );

  rvlab_tlul_host_mux #(.NumHosts(N), .MaxOutstanding(2)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .tl_h_i(h), .tl_h_o(h2_o),
    .tl_d_o(d2_o), .tl_d_i(d_i), .outstanding_o(outst2), .err_o(err2)
  );

  always_comb begin
    d_i         = '0;
    d_i.a_ready = dev_ardy;
    if (auto_rsp) begin
      d_i.d_valid  = auto_dv;
      d_i.d_data   = auto_data;
      d_i.d_source = 8'(auto_data[15:12]);
    end else begin
      d_i.d_valid = man_dv;
      d_i.d_data  = man_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Device emulation: answers accepted requests in order, data = address.
  logic [31:0] rq[$];
  initial begin
    bit          acc, pop, en;
    logic [31:0] a;
    auto_dv   = 1'b0;
    auto_data = '0;
    forever begin
      @(negedge clk);
      acc = !rst && d_o.a_valid && dev_ardy;
      a   = d_o.a_address;
      pop = auto_dv && d_o.d_ready;
      en  = auto_rsp;
      @(posedge clk);
      #1;
      if (!en || rst) begin
        rq.delete();
      end else begin
        if (pop) void'(rq.pop_front());
        if (acc) rq.push_back(a);
      end
      auto_dv   = (rq.size() != 0);
      auto_data = auto_dv ? rq[0] : 32'h0;
    end
  end

  // Reference model: FIFO of host indices, rr pointer, lock register.
  int mq[$];
  int mrr   = 0;
  bit mlock = 1'b0;
  int mlidx = 0;
  bit merr  = 1'b0;

  initial begin
    bit acc, pop, spur, gv, full, ne, eav, edr, edv, lock_set;
    int g, hd;
    forever begin
      @(negedge clk);
      acc = 0; pop = 0; spur = 0; lock_set = 0; g = 0; eav = 0;
      if (rst) begin
        mq.delete();
        mrr = 0; mlock = 0; merr = 0;
        chk("rst_a_valid", 32'(d_o.a_valid), 32'(0));
        chk("rst_d_ready", 32'(d_o.d_ready), 32'(0));
        chk("rst_outst", 32'(outst), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        for (int i = 0; i < N; i++) begin
          chk("rst_a_ready", 32'(h_o[i].a_ready), 32'(0));
          chk("rst_d_valid", 32'(h_o[i].d_valid), 32'(0));
        end
      end else begin
        full = (mq.size() == MAXO);
        ne   = (mq.size() != 0);
        hd   = ne ? mq[0] : 0;
        if (mlock) begin
          g  = mlidx;
          gv = h[g].a_valid;
        end else begin
          gv = 0;
          for (int k = 0; k < N; k++) begin
            if (!gv && h[(mrr + k) % N].a_valid) begin
              gv = 1;
              g  = (mrr + k) % N;
            end
          end
        end
        eav = gv && !full;
        if (ne) edr = h[hd].d_ready;
        else    edr = ERR_EN && d_i.d_valid;
        chk("m_a_valid", 32'(d_o.a_valid), 32'(eav));
        if (eav) begin
          chk("m_a_address", d_o.a_address, h[g].a_address);
          chk("m_a_source", 32'(d_o.a_source), 32'(h[g].a_source));
        end
        chk("m_d_ready", 32'(d_o.d_ready), 32'(edr));
        chk("m_outst", 32'(outst), 32'(mq.size()));
        chk("m_err", 32'(err), 32'(merr));
        for (int i = 0; i < N; i++) begin
          chk("m_a_ready", 32'(h_o[i].a_ready),
              32'(eav && dev_ardy && i == g));
          edv = ne && i == hd && d_i.d_valid;
          chk("m_d_valid", 32'(h_o[i].d_valid), 32'(edv));
          if (edv) chk("m_d_data", h_o[i].d_data, d_i.d_data);
        end
        acc      = eav && dev_ardy;
        pop      = ne && d_i.d_valid && edr;
        spur     = !ne && d_i.d_valid;
        lock_set = eav && !dev_ardy && !mlock;
      end
      @(posedge clk);
      if (!rst) begin
        if (pop) void'(mq.pop_front());
        if (acc) begin
          mq.push_back(g);
          mrr   = (g + 1) % N;
          mlock = 0;
        end else if (lock_set) begin
          mlock = 1;
          mlidx = g;
        end
        if (spur && ERR_EN) merr = 1;
      end
    end
  end

  // Grant log and per-host response routing.
  int gq[$];
  bit route_on = 1'b0;
  int rcnt [N];
  initial begin
    for (int i = 0; i < N; i++) rcnt[i] = 0;
    forever begin
      @(negedge clk);
      if (!rst && d_o.a_valid && dev_ardy)
        gq.push_back(int'(d_o.a_address[15:12]));
      if (route_on) begin
        for (int i = 0; i < N; i++) begin
          if (h_o[i].d_valid) begin
            chk("rsp_route", 32'(h_o[i].d_data[15:12]), 32'(i + 1));
            rcnt[i]++;
          end
        end
      end
    end
  end

  initial begin
    #20000;
    errors++;
    $display("FAIL watchdog got timeout want finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  int rr_exp [5] = '{1, 2, 3, 4, 1};
  int rs_exp [3] = '{1, 2, 3};

  initial begin
    rst      = 1'b0;
    dev_ardy = 1'b0;
    auto_rsp = 1'b1;
    man_dv   = 1'b0;
    man_data = '0;
    for (int i = 0; i < N; i++) begin
      h[i]           = '0;
      h[i].d_ready   = 1'b1;
      h[i].a_address = 32'h1000 * (i + 1);
      h[i].a_source  = 8'(i);
      h[i].a_data    = 32'hD000 + 32'(i);
    end
    #1 rst = 1'b1;
    repeat (2) tick();

    // Requests are blocked while reset is held.
    h[1].a_valid = 1'b1;
    dev_ardy     = 1'b1;
    @(negedge clk);
    chk("rst_hold_a_valid", 32'(d_o.a_valid), 32'(0));
    chk("rst_hold_a_ready", 32'(h_o[1].a_ready), 32'(0));
    h[1].a_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;

    // Round-robin with continuous requests from every host.
    gq.delete();
    route_on = 1'b1;
    for (int i = 0; i < N; i++) h[i].a_valid = 1'b1;
    repeat (8) tick();
    for (int i = 0; i < N; i++) h[i].a_valid = 1'b0;
    repeat (4) tick();
    route_on = 1'b0;
    for (int k = 0; k < 5; k++)
      chk("rr_order", 32'(gq.size() > k ? gq[k] : -1), 32'(rr_exp[k]));
    for (int i = 0; i < N; i++)
      chk("rr_rsp_count", 32'(rcnt[i]), 32'(2));
    @(negedge clk);
    chk("rr_drained", 32'(outst), 32'(0));

    // Grant lock on host 2 while host 0 joins.
    tick();
    h[2].a_valid = 1'b1;
    dev_ardy     = 1'b0;
    @(negedge clk);
    chk("lock_c1_addr", d_o.a_address, 32'h3000);
    tick();
    h[0].a_valid = 1'b1;
    @(negedge clk);
    chk("lock_c2_addr", d_o.a_address, 32'h3000);
    chk("lock_c2_h0_ready", 32'(h_o[0].a_ready), 32'(0));
    tick();
    @(negedge clk);
    chk("lock_c3_addr", d_o.a_address, 32'h3000);
    tick();
    dev_ardy = 1'b1;
    @(negedge clk);
    chk("lock_c4_addr", d_o.a_address, 32'h3000);
    chk("lock_c4_h2_ready", 32'(h_o[2].a_ready), 32'(1));
    tick();
    h[2].a_valid = 1'b0;
    @(negedge clk);
    chk("lock_next_addr", d_o.a_address, 32'h1000);
    chk("lock_next_valid", 32'(d_o.a_valid), 32'(1));
    tick();
    h[0].a_valid = 1'b0;
    repeat (4) tick();

    // Response backpressure from host 1.
    h[1].d_ready = 1'b0;
    h[1].a_valid = 1'b1;
    tick();
    h[1].a_valid = 1'b0;
    @(negedge clk);
    chk("bp_d_ready", 32'(d_o.d_ready), 32'(0));
    chk("bp_h1_valid", 32'(h_o[1].d_valid), 32'(1));
    chk("bp_others_valid",
        32'(h_o[0].d_valid | h_o[2].d_valid | h_o[3].d_valid), 32'(0));
    chk("bp_outst", 32'(outst), 32'(1));
    tick();
    @(negedge clk);
    chk("bp_outst_hold", 32'(outst), 32'(1));
    tick();
    h[1].d_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 32'(d_o.d_ready), 32'(1));
    tick();
    @(negedge clk);
    chk("bp_drained", 32'(outst), 32'(0));

    // FIFO full on the depth-2 instance.
    tick();
    auto_rsp = 1'b0;
    rst_pulse();
    h[0].a_valid = 1'b1;
    @(negedge clk);
    chk("full_c1_valid", 32'(d2_o.a_valid), 32'(1));
    tick();
    tick();
    @(negedge clk);
    chk("full_outst", 32'(outst2), 32'(2));
    chk("full_a_valid", 32'(d2_o.a_valid), 32'(0));
    chk("full_a_ready", 32'(h2_o[0].a_ready | h2_o[1].a_ready |
                            h2_o[2].a_ready | h2_o[3].a_ready), 32'(0));
    tick();
    tick();
    @(negedge clk);
    chk("full4_outst", 32'(outst), 32'(4));
    tick();
    man_dv   = 1'b1;
    man_data = 32'hABCD;
    @(negedge clk);
    chk("full_pop_dvalid", 32'(h2_o[0].d_valid), 32'(1));
    chk("full_pop_dready", 32'(d2_o.d_ready), 32'(1));
    chk("full_pop_noready", 32'(h2_o[0].a_ready), 32'(0));
    tick();
    man_dv = 1'b0;
    @(negedge clk);
    chk("full_after_outst", 32'(outst2), 32'(1));
    chk("full_after_ready", 32'(h2_o[0].a_ready), 32'(1));
    tick();
    h[0].a_valid = 1'b0;

    // Reset with three requests outstanding.
    rst_pulse();
    gq.delete();
    for (int i = 0; i < 3; i++) h[i].a_valid = 1'b1;
    tick();
    tick();
    tick();
    for (int i = 0; i < 3; i++) h[i].a_valid = 1'b0;
    @(negedge clk);
    chk("rs_outst", 32'(outst), 32'(3));
    for (int k = 0; k < 3; k++)
      chk("rs_order", 32'(gq.size() > k ? gq[k] : -1), 32'(rs_exp[k]));
    tick();
    h[0].d_ready = 1'b0;
    man_dv       = 1'b1;
    man_data     = 32'h5555;
    @(negedge clk);
    chk("rs_head_valid", 32'(h_o[0].d_valid), 32'(1));
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rs_async_outst", 32'(outst), 32'(0));
    chk("rs_async_dvalid", 32'(h_o[0].d_valid | h_o[1].d_valid |
                               h_o[2].d_valid | h_o[3].d_valid), 32'(0));
    chk("rs_async_avalid", 32'(d_o.a_valid), 32'(0));
    @(posedge clk);
    #2 rst = 1'b0;
    h[0].d_ready = 1'b1;
    @(negedge clk);
    chk("spur_d_ready", 32'(d_o.d_ready), 32'(ERR_EN));
    chk("spur_err_now", 32'(err), 32'(0));
    tick();
    man_dv = 1'b0;
    @(negedge clk);
    chk("spur_err_next", 32'(err), 32'(ERR_EN));
    tick();
    @(negedge clk);
    chk("spur_err_held", 32'(err), 32'(ERR_EN));
    tick();
    for (int i = 0; i < N; i++) h[i].a_valid = 1'b1;
    @(negedge clk);
    chk("resume_first", 32'(d_o.a_address[15:12]), 32'(1));
    chk("resume_ready", 32'(h_o[0].a_ready), 32'(1));
    tick();
    for (int i = 0; i < N; i++) h[i].a_valid = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
